// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Entries are allocated at tail, completed by writeback,
// and retired one per cycle from head (commit, branch resolution, or store handshake).
module reorder_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned WBP   = 2,
    parameter int unsigned TW    = $clog2(DEPTH)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                alloc_en_in,
    input  logic [1:0]          alloc_kind_in,
    input  logic [4:0]          alloc_dest_in,
    input  logic [AW-1:0]       alloc_pc_in,
    input  logic                alloc_pred_taken_in,
    input  logic [AW-1:0]       alloc_target_in,
    output logic                alloc_ready_out,
    output logic [TW-1:0]       alloc_tag_out,
    input  logic [WBP-1:0]      wb_valid_in,
    input  logic [WBP*TW-1:0]   wb_tag_in,
    input  logic [WBP*XLEN-1:0] wb_data_in,
    input  logic [WBP*AW-1:0]   wb_target_in,
    input  logic                sa_en_in,
    input  logic [TW-1:0]       sa_tag_in,
    input  logic [AW-1:0]       sa_addr_in,
    output logic                commit_en_out,
    output logic [4:0]          commit_dest_out,
    output logic [XLEN-1:0]     commit_data_out,
    output logic [TW-1:0]       commit_tag_out,
    output logic                bp_en_out,
    output logic                bp_correct_out,
    output logic [AW-1:0]       bp_pc_out,
    output logic                flush_out,
    output logic [AW-1:0]       flush_pc_out,
    output logic                st_req_out,
    output logic [AW-1:0]       st_addr_out,
    output logic [XLEN-1:0]     st_data_out,
    input  logic                st_ack_in,
    output logic [TW:0]         count_out
);

    typedef enum logic [1:0] {
        K_REG    = 2'b00,
        K_BRANCH = 2'b01,
        K_STORE  = 2'b10,
        K_JUMP   = 2'b11
    } kind_t;

    typedef enum logic {
        S_IDLE,
        S_STORE
    } state_t;

    localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

    logic [TW-1:0]   head_q, tail_q;
    logic [TW:0]     count_q;
    logic [DEPTH-1:0] busy_q, ready_q, addr_valid_q;
    kind_t           kind_q       [DEPTH];
    logic [4:0]      dest_q       [DEPTH];
    logic [AW-1:0]   pc_q         [DEPTH];
    logic            pred_q       [DEPTH];
    logic [AW-1:0]   target_q     [DEPTH];
    logic [AW-1:0]   res_target_q [DEPTH];
    logic [XLEN-1:0] value_q      [DEPTH];
    logic [AW-1:0]   addr_q       [DEPTH];

    state_t state_q, state_d;

    logic          alloc_fire;
    logic          head_live;
    logic          commit_ev, bp_ev, bp_ok, flush_ev, retire, store_start;
    logic [AW-1:0] flush_pc;

    assign alloc_ready_out = (count_q < FULL) && !flush_out;
    assign alloc_tag_out   = tail_q;
    assign count_out       = count_q;
    assign alloc_fire      = rdy_in && alloc_en_in && alloc_ready_out;
    assign head_live       = busy_q[head_q] && ready_q[head_q];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        commit_ev   = 1'b0;
        bp_ev       = 1'b0;
        bp_ok       = 1'b0;
        flush_ev    = 1'b0;
        flush_pc    = '0;
        retire      = 1'b0;
        store_start = 1'b0;
        if (rdy_in) begin
            unique case (state_q)
                S_IDLE: begin
                    if (head_live) begin
                        unique case (kind_q[head_q])
                            K_REG: begin
                                commit_ev = 1'b1;
                                retire    = 1'b1;
                            end
                            K_BRANCH: begin
                                bp_ev = 1'b1;
                                bp_ok = (pred_q[head_q] == value_q[head_q][0]);
                                if (bp_ok) begin
                                    retire = 1'b1;
                                end else begin
                                    flush_ev = 1'b1;
                                    flush_pc = value_q[head_q][0] ? res_target_q[head_q]
                                                                  : pc_q[head_q] + AW'(4);
                                end
                            end
                            K_JUMP: begin
                                commit_ev = 1'b1;
                                if (res_target_q[head_q] != target_q[head_q]) begin
                                    flush_ev = 1'b1;
                                    flush_pc = res_target_q[head_q];
                                end else begin
                                    retire = 1'b1;
                                end
                            end
                            K_STORE: begin
                                if (addr_valid_q[head_q]) begin
                                    store_start = 1'b1;
                                    state_d     = S_STORE;
                                end
                            end
                        endcase
                    end
                end
                S_STORE: begin
                    if (st_ack_in) begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            addr_valid_q    <= '0;
            commit_en_out   <= 1'b0;
            commit_dest_out <= '0;
            commit_data_out <= '0;
            commit_tag_out  <= '0;
            bp_en_out       <= 1'b0;
            bp_correct_out  <= 1'b0;
            bp_pc_out       <= '0;
            flush_out       <= 1'b0;
            flush_pc_out    <= '0;
            st_req_out      <= 1'b0;
            st_addr_out     <= '0;
            st_data_out     <= '0;
        end else begin
            commit_en_out <= commit_ev;
            bp_en_out     <= bp_ev;
            flush_out     <= flush_ev;
            if (commit_ev) begin
                commit_dest_out <= dest_q[head_q];
                commit_data_out <= value_q[head_q];
                commit_tag_out  <= head_q;
            end
            if (bp_ev) begin
                bp_correct_out <= bp_ok;
                bp_pc_out      <= pc_q[head_q];
            end
            if (flush_ev) begin
                flush_pc_out <= flush_pc;
            end
            if (store_start) begin
                st_req_out  <= 1'b1;
                st_addr_out <= addr_q[head_q];
                st_data_out <= value_q[head_q];
            end else if (state_q == S_STORE && retire) begin
                st_req_out <= 1'b0;
            end

            if (flush_ev) begin
                busy_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else if (rdy_in) begin
                // Later ports overwrite earlier ones, so the highest index wins on a tag clash.
                for (int unsigned p = 0; p < WBP; p++) begin
                    if (wb_valid_in[p] && busy_q[wb_tag_in[p*TW +: TW]]) begin
                        ready_q[wb_tag_in[p*TW +: TW]]      <= 1'b1;
                        value_q[wb_tag_in[p*TW +: TW]]      <= wb_data_in[p*XLEN +: XLEN];
                        res_target_q[wb_tag_in[p*TW +: TW]] <= wb_target_in[p*AW +: AW];
                    end
                end
                if (sa_en_in && busy_q[sa_tag_in]) begin
                    addr_q[sa_tag_in]       <= sa_addr_in;
                    addr_valid_q[sa_tag_in] <= 1'b1;
                end
                if (alloc_fire) begin
                    busy_q[tail_q]       <= 1'b1;
                    ready_q[tail_q]      <= 1'b0;
                    addr_valid_q[tail_q] <= 1'b0;
                    kind_q[tail_q]       <= kind_t'(alloc_kind_in);
                    dest_q[tail_q]       <= alloc_dest_in;
                    pc_q[tail_q]         <= alloc_pc_in;
                    pred_q[tail_q]       <= alloc_pred_taken_in;
                    target_q[tail_q]     <= alloc_target_in;
                    tail_q               <= tail_q + TW'(1);
                end
                if (retire) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + TW'(1);
                end
                unique case ({alloc_fire, retire})
                    2'b10:   count_q <= count_q + (TW+1)'(1);
                    2'b01:   count_q <= count_q - (TW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized
// register-only run compared against a queue model of in-order retirement.
module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int WBP   = 2;
    localparam int TW    = 4;

    localparam logic [1:0] REG = 2'b00, BR = 2'b01, ST = 2'b10, JMP = 2'b11;

    logic                clk_in = 1'b0;
    logic                rst_in, rdy_in;
    logic                alloc_en_in;
    logic [1:0]          alloc_kind_in;
    logic [4:0]          alloc_dest_in;
    logic [AW-1:0]       alloc_pc_in;
    logic                alloc_pred_taken_in;
    logic [AW-1:0]       alloc_target_in;
    logic                alloc_ready_out;
    logic [TW-1:0]       alloc_tag_out;
    logic [WBP-1:0]      wb_valid_in;
    logic [WBP*TW-1:0]   wb_tag_in;
    logic [WBP*XLEN-1:0] wb_data_in;
    logic [WBP*AW-1:0]   wb_target_in;
    logic                sa_en_in;
    logic [TW-1:0]       sa_tag_in;
    logic [AW-1:0]       sa_addr_in;
    logic                commit_en_out;
    logic [4:0]          commit_dest_out;
    logic [XLEN-1:0]     commit_data_out;
    logic [TW-1:0]       commit_tag_out;
    logic                bp_en_out, bp_correct_out;
    logic [AW-1:0]       bp_pc_out;
    logic                flush_out;
    logic [AW-1:0]       flush_pc_out;
    logic                st_req_out;
    logic [AW-1:0]       st_addr_out;
    logic [XLEN-1:0]     st_data_out;
    logic                st_ack_in;
    logic [TW:0]         count_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW), .WBP(WBP), .TW(TW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_en_in(alloc_en_in), .alloc_kind_in(alloc_kind_in), .alloc_dest_in(alloc_dest_in),
        .alloc_pc_in(alloc_pc_in), .alloc_pred_taken_in(alloc_pred_taken_in),
        .alloc_target_in(alloc_target_in), .alloc_ready_out(alloc_ready_out),
        .alloc_tag_out(alloc_tag_out), .wb_valid_in(wb_valid_in), .wb_tag_in(wb_tag_in),
        .wb_data_in(wb_data_in), .wb_target_in(wb_target_in), .sa_en_in(sa_en_in),
        .sa_tag_in(sa_tag_in), .sa_addr_in(sa_addr_in), .commit_en_out(commit_en_out),
        .commit_dest_out(commit_dest_out), .commit_data_out(commit_data_out),
        .commit_tag_out(commit_tag_out), .bp_en_out(bp_en_out), .bp_correct_out(bp_correct_out),
        .bp_pc_out(bp_pc_out), .flush_out(flush_out), .flush_pc_out(flush_pc_out),
        .st_req_out(st_req_out), .st_addr_out(st_addr_out), .st_data_out(st_data_out),
        .st_ack_in(st_ack_in), .count_out(count_out)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rst_in              = 1'b0;
        rdy_in              = 1'b1;
        alloc_en_in         = 1'b0;
        alloc_kind_in       = REG;
        alloc_dest_in       = '0;
        alloc_pc_in         = '0;
        alloc_pred_taken_in = 1'b0;
        alloc_target_in     = '0;
        wb_valid_in         = '0;
        wb_tag_in           = '0;
        wb_data_in          = '0;
        wb_target_in        = '0;
        sa_en_in            = 1'b0;
        sa_tag_in           = '0;
        sa_addr_in          = '0;
        st_ack_in           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic set_alloc(input logic [1:0] k, input logic [4:0] d, input logic [AW-1:0] pc,
                             input logic pt, input logic [AW-1:0] tg);
        alloc_en_in         = 1'b1;
        alloc_kind_in       = k;
        alloc_dest_in       = d;
        alloc_pc_in         = pc;
        alloc_pred_taken_in = pt;
        alloc_target_in     = tg;
    endtask

    task automatic set_wb(input int p, input logic [TW-1:0] t, input logic [XLEN-1:0] d,
                          input logic [AW-1:0] tg);
        wb_valid_in[p]            = 1'b1;
        wb_tag_in[p*TW +: TW]     = t;
        wb_data_in[p*XLEN +: XLEN] = d;
        wb_target_in[p*AW +: AW]  = tg;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b1;
        set_alloc(REG, 5'd9, 32'h40, 1'b1, 32'h80);
        set_wb(0, 4'd0, 32'hDEAD, 32'h0);
        st_ack_in = 1'b1;
        tick();
        idle_inputs();
        checks++; if ({commit_en_out, bp_en_out, bp_correct_out, flush_out, st_req_out} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b exp 00000",
                {commit_en_out, bp_en_out, bp_correct_out, flush_out, st_req_out}); end
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count_out); end
        checks++; if (alloc_tag_out !== 4'd0) begin errors++; $display("FAIL reset_tag: got %0d exp 0", alloc_tag_out); end
        checks++; if ({commit_data_out, commit_dest_out, commit_tag_out, bp_pc_out, flush_pc_out, st_addr_out, st_data_out} !== '0) begin
            errors++; $display("FAIL reset_payload: got nonzero payload exp all 0"); end
    endtask

    task automatic test_fill();
        logic [XLEN-1:0] v;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (alloc_ready_out !== 1'b1 || alloc_tag_out !== 4'(i)) begin errors++;
                $display("FAIL fill_alloc_%0d: got ready=%b tag=%0d exp ready=1 tag=%0d", i, alloc_ready_out, alloc_tag_out, i); end
            set_alloc(REG, 5'(i + 1), 32'(i * 4), 1'b0, '0);
            tick();
        end
        checks++; if (alloc_ready_out !== 1'b0 || count_out !== 5'd16) begin errors++;
            $display("FAIL fill_full: got ready=%b count=%0d exp ready=0 count=16", alloc_ready_out, count_out); end
        tick();
        idle_inputs();
        checks++; if (count_out !== 5'd16) begin errors++; $display("FAIL fill_overalloc: got %0d exp 16", count_out); end
        v = $urandom;
        set_wb(0, 4'd0, v, '0);
        tick();
        idle_inputs();
        checks++; if (commit_en_out !== 1'b0) begin errors++; $display("FAIL fill_early_commit: got %b exp 0", commit_en_out); end
        tick();
        checks++; if (commit_en_out !== 1'b1 || commit_tag_out !== 4'd0 || commit_data_out !== v || commit_dest_out !== 5'd1) begin
            errors++; $display("FAIL fill_commit: got en=%b tag=%0d data=%h dest=%0d exp en=1 tag=0 data=%h dest=1",
                commit_en_out, commit_tag_out, commit_data_out, commit_dest_out, v); end
        checks++; if (count_out !== 5'd15 || alloc_ready_out !== 1'b1 || alloc_tag_out !== 4'd0) begin errors++;
            $display("FAIL fill_after_commit: got count=%0d ready=%b tag=%0d exp 15 1 0", count_out, alloc_ready_out, alloc_tag_out); end
        set_alloc(REG, 5'd20, '0, 1'b0, '0);
        tick();
        idle_inputs();
        checks++; if (count_out !== 5'd16 || alloc_ready_out !== 1'b0 || commit_en_out !== 1'b0) begin errors++;
            $display("FAIL fill_refill: got count=%0d ready=%b en=%b exp 16 0 0", count_out, alloc_ready_out, commit_en_out); end
    endtask

    task automatic test_branch();
        do_reset();
        set_alloc(BR, 5'd0, 32'h100, 1'b0, 32'h180);
        tick();
        set_alloc(REG, 5'd2, 32'h104, 1'b0, '0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'h1, 32'h200);
        tick();
        idle_inputs();
        set_alloc(REG, 5'd3, 32'h108, 1'b0, '0);
        tick();
        idle_inputs();
        checks++; if ({bp_en_out, bp_correct_out, flush_out} !== 3'b101 || bp_pc_out !== 32'h100 || flush_pc_out !== 32'h200) begin
            errors++; $display("FAIL br_mispredict: got bp=%b ok=%b fl=%b pc=%h fpc=%h exp 1 0 1 100 200",
                bp_en_out, bp_correct_out, flush_out, bp_pc_out, flush_pc_out); end
        checks++; if (count_out !== 5'd0 || alloc_tag_out !== 4'd0 || alloc_ready_out !== 1'b0) begin errors++;
            $display("FAIL br_flush_state: got count=%0d tag=%0d ready=%b exp 0 0 0", count_out, alloc_tag_out, alloc_ready_out); end
        tick();
        checks++; if ({bp_en_out, flush_out, commit_en_out} !== 3'b000 || alloc_ready_out !== 1'b1 || count_out !== 5'd0) begin
            errors++; $display("FAIL br_after_flush: got bp=%b fl=%b en=%b ready=%b count=%0d exp 0 0 0 1 0",
                bp_en_out, flush_out, commit_en_out, alloc_ready_out, count_out); end
        set_alloc(BR, 5'd0, 32'h300, 1'b1, 32'h400);
        tick();
        idle_inputs();
        set_wb(1, 4'd0, 32'h1, 32'h400);
        tick();
        idle_inputs();
        tick();
        checks++; if ({bp_en_out, bp_correct_out, flush_out} !== 3'b110 || bp_pc_out !== 32'h300 || count_out !== 5'd0) begin
            errors++; $display("FAIL br_correct: got bp=%b ok=%b fl=%b pc=%h count=%0d exp 1 1 0 300 0",
                bp_en_out, bp_correct_out, flush_out, bp_pc_out, count_out); end
        set_alloc(BR, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'h500);
        tick();
        idle_inputs();
        set_wb(0, 4'd1, 32'h0, 32'h500);
        tick();
        idle_inputs();
        tick();
        checks++; if ({bp_en_out, bp_correct_out, flush_out} !== 3'b101 || flush_pc_out !== 32'h0) begin
            errors++; $display("FAIL br_wrap_pc4: got bp=%b ok=%b fl=%b fpc=%h exp 1 0 1 0",
                bp_en_out, bp_correct_out, flush_out, flush_pc_out); end
    endtask

    task automatic test_store();
        logic [XLEN-1:0] rv;
        rv = $urandom;
        do_reset();
        set_alloc(ST, 5'd0, 32'h200, 1'b0, '0);
        tick();
        set_alloc(REG, 5'd7, 32'h204, 1'b0, '0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'hAB, '0);
        set_wb(1, 4'd1, rv, '0);
        tick();
        idle_inputs();
        tick();
        tick();
        checks++; if (st_req_out !== 1'b0 || commit_en_out !== 1'b0 || count_out !== 5'd2) begin errors++;
            $display("FAIL st_no_addr: got req=%b en=%b count=%0d exp 0 0 2", st_req_out, commit_en_out, count_out); end
        sa_en_in = 1'b1; sa_tag_in = 4'd0; sa_addr_in = 32'h30000;
        tick();
        idle_inputs();
        tick();
        checks++; if (st_req_out !== 1'b1 || st_addr_out !== 32'h30000 || st_data_out !== 32'hAB) begin errors++;
            $display("FAIL st_req: got req=%b addr=%h data=%h exp 1 30000 ab", st_req_out, st_addr_out, st_data_out); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (st_req_out !== 1'b1 || commit_en_out !== 1'b0 || count_out !== 5'd2) begin errors++;
                $display("FAIL st_wait_%0d: got req=%b en=%b count=%0d exp 1 0 2", k, st_req_out, commit_en_out, count_out); end
        end
        st_ack_in = 1'b1;
        tick();
        st_ack_in = 1'b0;
        checks++; if (st_req_out !== 1'b0 || count_out !== 5'd1 || commit_en_out !== 1'b0) begin errors++;
            $display("FAIL st_ack: got req=%b count=%0d en=%b exp 0 1 0", st_req_out, count_out, commit_en_out); end
        tick();
        checks++; if (commit_en_out !== 1'b1 || commit_tag_out !== 4'd1 || commit_data_out !== rv || commit_dest_out !== 5'd7 || count_out !== 5'd0) begin
            errors++; $display("FAIL st_younger: got en=%b tag=%0d data=%h dest=%0d count=%0d exp 1 1 %h 7 0",
                commit_en_out, commit_tag_out, commit_data_out, commit_dest_out, count_out, rv); end
    endtask

    task automatic test_same_tag();
        logic [XLEN-1:0] a, b;
        a = $urandom; b = a ^ 32'h5A5A_0001;
        do_reset();
        set_alloc(REG, 5'd3, '0, 1'b0, '0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, a, '0);
        set_wb(1, 4'd0, b, '0);
        tick();
        idle_inputs();
        tick();
        checks++; if (commit_en_out !== 1'b1 || commit_data_out !== b || commit_tag_out !== 4'd0) begin errors++;
            $display("FAIL same_tag: got en=%b data=%h tag=%0d exp 1 %h 0", commit_en_out, commit_data_out, commit_tag_out, b); end
        set_alloc(REG, 5'd4, '0, 1'b0, '0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'h1234, '0);
        tick();
        idle_inputs();
        tick();
        checks++; if (commit_en_out !== 1'b0 || count_out !== 5'd1) begin errors++;
            $display("FAIL freed_tag: got en=%b count=%0d exp 0 1", commit_en_out, count_out); end
    endtask

    task automatic test_jump();
        logic [XLEN-1:0] v1, v2;
        v1 = $urandom; v2 = $urandom;
        do_reset();
        set_alloc(JMP, 5'd5, 32'h1000, 1'b0, 32'h40);
        tick();
        set_alloc(JMP, 5'd6, 32'h1004, 1'b0, 32'h40);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, v1, 32'h40);
        set_wb(1, 4'd1, v2, 32'h44);
        tick();
        idle_inputs();
        tick();
        checks++; if (commit_en_out !== 1'b1 || commit_data_out !== v1 || flush_out !== 1'b0 || count_out !== 5'd1) begin
            errors++; $display("FAIL jump_match: got en=%b data=%h fl=%b count=%0d exp 1 %h 0 1",
                commit_en_out, commit_data_out, flush_out, count_out, v1); end
        tick();
        checks++; if (commit_en_out !== 1'b1 || commit_dest_out !== 5'd6 || flush_out !== 1'b1 || flush_pc_out !== 32'h44 || count_out !== 5'd0) begin
            errors++; $display("FAIL jump_redirect: got en=%b dest=%0d fl=%b fpc=%h count=%0d exp 1 6 1 44 0",
                commit_en_out, commit_dest_out, flush_out, flush_pc_out, count_out); end
    endtask

    task automatic test_rdy_freeze();
        logic [XLEN-1:0] v;
        v = $urandom;
        do_reset();
        set_alloc(REG, 5'd8, '0, 1'b0, '0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, v, '0);
        tick();
        idle_inputs();
        rdy_in = 1'b0;
        set_alloc(REG, 5'd9, '0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (commit_en_out !== 1'b0 || count_out !== 5'd1) begin errors++;
                $display("FAIL freeze_%0d: got en=%b count=%0d exp 0 1", k, commit_en_out, count_out); end
        end
        idle_inputs();
        tick();
        checks++; if (commit_en_out !== 1'b1 || commit_data_out !== v || count_out !== 5'd0) begin errors++;
            $display("FAIL unfreeze: got en=%b data=%h count=%0d exp 1 %h 0", commit_en_out, commit_data_out, count_out, v); end
    endtask

    task automatic test_reset_store();
        do_reset();
        set_alloc(ST, 5'd0, '0, 1'b0, '0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'h77, '0);
        sa_en_in = 1'b1; sa_tag_in = 4'd0; sa_addr_in = 32'h40;
        tick();
        idle_inputs();
        tick();
        checks++; if (st_req_out !== 1'b1) begin errors++; $display("FAIL rst_st_pre: got %b exp 1", st_req_out); end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checks++; if ({st_req_out, commit_en_out, bp_en_out, flush_out} !== 4'b0 || count_out !== 5'd0 || st_addr_out !== '0 || st_data_out !== '0) begin
            errors++; $display("FAIL rst_st: got req=%b en=%b bp=%b fl=%b count=%0d addr=%h exp all 0",
                st_req_out, commit_en_out, bp_en_out, flush_out, count_out, st_addr_out); end
        tick();
        checks++; if (st_req_out !== 1'b0) begin errors++; $display("FAIL rst_st_post: got %b exp 0", st_req_out); end
    endtask

    typedef struct {
        logic [TW-1:0]   tag;
        logic [4:0]      dest;
        logic            done;
        logic [XLEN-1:0] val;
    } ent_t;

    task automatic test_random();
        ent_t q[$];
        int tail_m;
        bit exp_commit;
        ent_t head;
        do_reset();
        tail_m = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle_inputs();
            checks++; if (alloc_ready_out !== (q.size() < DEPTH) || alloc_tag_out !== 4'(tail_m)) begin errors++;
                $display("FAIL rnd_alloc_if c%0d: got ready=%b tag=%0d exp %b %0d", cyc, alloc_ready_out, alloc_tag_out, q.size() < DEPTH, tail_m); end
            rdy_in = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) < ((cyc / 150) % 2 == 0 ? 80 : 30))
                set_alloc(REG, 5'($urandom), '0, 1'b0, '0);
            for (int p = 0; p < WBP; p++) begin
                if ($urandom_range(0, 99) < ((cyc / 150) % 2 == 0 ? 20 : 60)) begin
                    if (q.size() > 0 && $urandom_range(0, 3) != 0)
                        set_wb(p, q[$urandom_range(0, q.size() - 1)].tag, $urandom, '0);
                    else
                        set_wb(p, 4'($urandom), $urandom, '0);
                end
            end
            if (wb_valid_in == 2'b11 && $urandom_range(0, 3) == 0)
                wb_tag_in[TW +: TW] = wb_tag_in[0 +: TW];
            exp_commit = 1'b0;
            if (rdy_in) begin
                exp_commit = (q.size() > 0) && q[0].done;
                if (exp_commit) head = q[0];
                for (int p = 0; p < WBP; p++) begin
                    if (wb_valid_in[p]) begin
                        foreach (q[i]) begin
                            if (q[i].tag == wb_tag_in[p*TW +: TW]) begin
                                q[i].done = 1'b1;
                                q[i].val  = wb_data_in[p*XLEN +: XLEN];
                            end
                        end
                    end
                end
                if (alloc_en_in && q.size() < DEPTH) begin
                    q.push_back('{tag: 4'(tail_m), dest: alloc_dest_in, done: 1'b0, val: '0});
                    tail_m = (tail_m + 1) % DEPTH;
                end
                if (exp_commit) void'(q.pop_front());
            end
            tick();
            checks++; if (commit_en_out !== exp_commit) begin errors++;
                $display("FAIL rnd_commit_en c%0d: got %b exp %b", cyc, commit_en_out, exp_commit); end
            if (exp_commit) begin
                checks++; if (commit_tag_out !== head.tag || commit_data_out !== head.val || commit_dest_out !== head.dest) begin
                    errors++; $display("FAIL rnd_payload c%0d: got tag=%0d data=%h dest=%0d exp %0d %h %0d",
                        cyc, commit_tag_out, commit_data_out, commit_dest_out, head.tag, head.val, head.dest); end
            end
            checks++; if (count_out !== 5'(q.size())) begin errors++;
                $display("FAIL rnd_count c%0d: got %0d exp %0d", cyc, count_out, q.size()); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_branch();
        test_store();
        test_same_tag();
        test_jump();
        test_rdy_freeze();
        test_reset_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
